scan_display_n: RTL and testbench

//  Parametrised N-digit multiplexed display scanner. Successor to the fixed 4-digit scanner.

---
 rtl/scan_display_n.sv | 140 ++++++++++++++
 tb/tb_scan_display_n.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/scan_display_n.sv
// N-digit multiplexed display scanner: prescaled digit scan, frame-coherent snapshot,
// leading-zero blanking, per-digit blink and decimal points, all outputs registered.
module scan_display_n #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned DIV          = 1000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned EN_ACT_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [DIGITS-1:0]     dp,
    output logic [3:0]            Dout,
    output logic [DIGITS-1:0]     Eout,
    output logic [7:0]            seg,
    output logic                  frame
);

    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned DW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] EN_OFF = (EN_ACT_LOW != 0) ? {DIGITS{1'b1}} : '0;

    logic [PW-1:0]     pre_cnt;
    logic [IW-1:0]     idx;
    logic [DW-1:0]     snap_data;
    logic [DIGITS-1:0] snap_blink;
    logic [DIGITS-1:0] snap_dp;
    logic [BW-1:0]     blink_cnt;
    logic              blink_ph;

    logic              tick_c;
    logic              last_c;
    logic              frame_start_c;
    logic [3:0]        code_c;
    logic              cur_dp_c;
    logic              cur_blink_c;
    logic              upper_zero_c;
    logic              blank_c;
    logic [DIGITS-1:0] onehot_c;
    logic [DIGITS-1:0] en_c;
    logic [7:0]        seg_c;

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick_c        = (pre_cnt == PW'(DIV - 1));
    assign last_c        = (idx == IW'(DIGITS - 1));
    assign frame_start_c = tick_c & last_c;

    // Select the scanned digit and check whether it and every more significant digit are zero.
    always_comb begin
        code_c       = '0;
        cur_dp_c     = 1'b0;
        cur_blink_c  = 1'b0;
        upper_zero_c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IW'(i) == idx) begin
                code_c      = snap_data[4*i +: 4];
                cur_dp_c    = snap_dp[i];
                cur_blink_c = snap_blink[i];
            end
            if ((IW'(i) >= idx) && (snap_data[4*i +: 4] != 4'h0)) begin
                upper_zero_c = 1'b0;
            end
        end
    end

    always_comb begin
        blank_c  = (cur_blink_c & blink_ph) | (blank_lz & (idx != '0) & upper_zero_c);
        onehot_c = DIGITS'(1) << idx;
        en_c     = EN_OFF;
        seg_c    = 8'h00;
        if (!blank_c) begin
            en_c  = (EN_ACT_LOW != 0) ? ~onehot_c : onehot_c;
            seg_c = {cur_dp_c, decode(code_c)};
        end
    end

    // Scan counters, frame snapshot, blink phase and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt    <= '0;
            idx        <= '0;
            snap_data  <= '0;
            snap_blink <= '0;
            snap_dp    <= '0;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            Dout       <= 4'h0;
            Eout       <= EN_OFF;
            seg        <= 8'h00;
            frame      <= 1'b0;
        end else begin
            pre_cnt <= tick_c ? '0 : pre_cnt + PW'(1);
            if (tick_c) begin
                idx <= last_c ? '0 : idx + IW'(1);
            end
            frame <= frame_start_c;
            if (frame_start_c) begin
                snap_data  <= data;
                snap_blink <= blink_mask;
                snap_dp    <= dp;
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
            Dout <= code_c;
            Eout <= en_c;
            seg  <= seg_c;
        end
    end

endmodule

// File: tb/tb_scan_display_n.sv
// Bench for scan_display_n: directed scenarios plus random traffic, checked every cycle
// against a time-based model (slot and frame derived from the cycle count since reset).
module tb_scan_display_n;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int BF     = 2;
    localparam int FR     = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data = 16'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = 4'h0;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  Dout, Dout_h;
    logic [3:0]  Eout, Eout_h;
    logic [7:0]  seg, seg_h;
    logic        frame, frame_h;

    int n_checks = 0;
    int n_err    = 0;

    scan_display_n #(.DIGITS(DIGITS), .DIV(DIV), .BLINK_FRAMES(BF), .EN_ACT_LOW(1)) dut (
        .clk(clk), .rst(rst), .data(data), .blank_lz(blank_lz), .blink_mask(blink_mask),
        .dp(dp), .Dout(Dout), .Eout(Eout), .seg(seg), .frame(frame));

    scan_display_n #(.DIGITS(DIGITS), .DIV(DIV), .BLINK_FRAMES(BF), .EN_ACT_LOW(0)) dut_h (
        .clk(clk), .rst(rst), .data(data), .blank_lz(blank_lz), .blink_mask(blink_mask),
        .dp(dp), .Dout(Dout_h), .Eout(Eout_h), .seg(seg_h), .frame(frame_h));

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: edges since reset and the data latched at the last frame boundary.
    int          n = 0;
    logic [15:0] s_data = 16'h0;
    logic [3:0]  s_blink = 4'h0;
    logic [3:0]  s_dp = 4'h0;
    logic [3:0]  e_dout;
    logic [3:0]  e_eout, e_eouth;
    logic [7:0]  e_seg;
    logic        e_frame;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        int          slot;
        int          ph;
        logic [15:0] upper;
        logic        blank;
        if (!rst) begin
            n = 0;
            s_data = 16'h0; s_blink = 4'h0; s_dp = 4'h0;
            e_dout = 4'h0; e_seg = 8'h00; e_frame = 1'b0;
            e_eout = 4'hF; e_eouth = 4'h0;
        end else begin
            slot    = (n / DIV) % DIGITS;
            ph      = ((n / FR) / BF) % 2;
            upper   = s_data >> (4 * slot);
            blank   = (s_blink[slot] && ph == 1) || (blank_lz && slot != 0 && upper == 16'h0);
            e_dout  = upper[3:0];
            e_seg   = blank ? 8'h00 : {s_dp[slot], seg_tab[upper[3:0]]};
            e_eout  = blank ? 4'hF : ~4'(1 << slot);
            e_eouth = blank ? 4'h0 : 4'(1 << slot);
            e_frame = ((n + 1) % FR) == 0;
            if (e_frame) begin
                s_data = data; s_blink = blink_mask; s_dp = dp;
            end
            n++;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("dout", 32'(Dout), 32'(e_dout));
        check("eout", 32'(Eout), 32'(e_eout));
        check("seg", 32'(seg), 32'(e_seg));
        check("frame", 32'(frame), 32'(e_frame));
        check("eout_hi", 32'(Eout_h), 32'(e_eouth));
        check("seg_hi", 32'(seg_h), 32'(e_seg));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] d;
        d = 16'h0;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) d[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        return d;
    endfunction

    initial begin
        // scan order
        rst = 1'b0; data = 16'h0102;
        run(2);
        rst = 1'b1;
        run(2 * FR + 4);
        // leading zeros, including the all-zero value
        data = 16'h0005; blank_lz = 1'b1;
        run(2 * FR);
        data = 16'h0000;
        run(2 * FR);
        // mid-frame data change
        blank_lz = 1'b0; data = 16'h1111;
        run(FR);
        while (((n / DIV) % DIGITS) != 2) cycle();
        data = 16'h2222;
        run(2 * FR);
        // blink
        blink_mask = 4'b0001;
        run(6 * FR);
        blink_mask = 4'b0000;
        // reset mid-frame
        while (((n / DIV) % DIGITS) != 2) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        run(FR + 4);
        // hex and decimal point
        data = 16'h00A0; dp = 4'b0010;
        run(2 * FR);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) data = rand_data();
            if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) dp = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
